// File: rtl/ks10_mem_ctrl.sv
// ks10_mem_ctrl: KS-10 main-memory controller.
// Serves KS-10 bus requests from a pipelined synchronous SRAM and answers the
// Memory Status Register at IO address 0o100000 with a registered
// request/acknowledge handshake.
// KS-10 bit k of a bus word maps to vector index 35-k here (bit 0 is the MSB).
module ks10_mem_ctrl #(
  parameter int MEM_AWIDTH = 15,
  parameter int SSRAM_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        busREQI,
  output logic        busACKO,
  input  logic [35:0] busADDRI,
  input  logic [35:0] busDATAI,
  output logic [35:0] busDATAO,
  output logic        ssramCLK,
  output logic [22:0] ssramADDR,
  output logic [35:0] ssramDATAO,
  input  logic [35:0] ssramDATAI,
  output logic        ssramDOE,
  output logic        ssramWR,
  output logic        ssramADV
);

  typedef enum logic [2:0] {IDLE, RD, WR, STAT, ACK, HOLD} stateT;

  // KS-10 bit positions expressed as vector indices
  localparam int BIT_READ  = 35 - 3;
  localparam int BIT_WRITE = 35 - 5;
  localparam int BIT_IO    = 35 - 10;
  localparam int BIT_PE    = 35 - 3;
  localparam int BIT_PF    = 35 - 12;
  localparam int BIT_EE    = 35 - 35;

  localparam logic [19:0] ADDR_MASK = 20'((64'd1 << MEM_AWIDTH) - 64'd1);
  localparam logic [2:0]  LAT_INIT  = 3'(SSRAM_LAT);
  localparam logic [19:0] STAT_ADDR = 20'o100000;

  stateT       stateReg, stateNext;
  logic        ackReg, ackNext;
  logic        wrReg, wrNext;
  logic        doeReg, doeNext;
  logic [2:0]  cntReg, cntNext;
  logic [35:0] dataoReg, dataoNext;
  logic [22:0] addrReg, addrNext;
  logic [35:0] wdataReg, wdataNext;
  logic        peReg, peNext;
  logic        eeReg, eeNext;
  logic        pfReg, pfNext;
  logic        isWrReg, isWrNext;
  logic        abortReg, abortNext;

  // request decode
  logic        reqRead, reqWrite, reqIO, reqAny;
  logic [3:0]  reqDev;
  logic [19:0] reqAddr;
  logic [31:0] reqAddrWide;
  logic        memInRange, memHit, statHit, aborted;
  logic [35:0] statWord;

  // bus address bits this controller does not decode
  logic unusedAddrBits;
  assign unusedAddrBits = ^{busADDRI[35:33], busADDRI[31], busADDRI[29:26], busADDRI[24:22]};

  assign reqRead     = busADDRI[BIT_READ];
  assign reqWrite    = busADDRI[BIT_WRITE];
  assign reqIO       = busADDRI[BIT_IO];
  assign reqDev      = busADDRI[21:18];
  assign reqAddr     = busADDRI[19:0];
  assign reqAddrWide = {12'b0, reqAddr};
  assign reqAny      = reqRead | reqWrite;
  assign memInRange  = (reqAddrWide >> MEM_AWIDTH) == 32'd0;
  assign memHit      = !reqIO && memInRange && reqAny;
  assign statHit     = reqIO && (reqDev == 4'd0) && (reqAddr == STAT_ADDR) && reqAny;
  // a request dropped at any point of an SSRAM cycle suppresses its ack
  assign aborted     = abortReg | ~busREQI;
  assign statWord    = {3'b0, peReg, eeReg, 7'b0, pfReg, 23'b0};

  // next-state and next-register values for every FSM state
  always_comb begin
    stateNext = stateReg;
    ackNext   = 1'b0;
    wrNext    = 1'b0;
    doeNext   = 1'b0;
    cntNext   = cntReg;
    dataoNext = dataoReg;
    addrNext  = addrReg;
    wdataNext = wdataReg;
    peNext    = peReg;
    eeNext    = eeReg;
    pfNext    = pfReg;
    isWrNext  = isWrReg;
    abortNext = abortReg;
    case (stateReg)
      IDLE: begin
        if (busREQI) begin
          if (memHit) begin
            addrNext  = {3'b0, reqAddr & ADDR_MASK};
            isWrNext  = reqWrite;
            abortNext = 1'b0;
            if (reqWrite) begin
              // write wins when READ and WRITE are both set
              stateNext = WR;
              wdataNext = busDATAI;
              wrNext    = 1'b1;
              doeNext   = 1'b1;
            end else begin
              stateNext = RD;
              cntNext   = LAT_INIT;
            end
          end else if (statHit) begin
            stateNext = STAT;
            isWrNext  = reqWrite;
          end
        end
      end
      RD: begin
        abortNext = aborted;
        if (cntReg == 3'd0) begin
          dataoNext = ssramDATAI;
          stateNext = aborted ? IDLE : ACK;
          ackNext   = ~aborted;
        end else begin
          cntNext = cntReg - 3'd1;
        end
      end
      WR: begin
        stateNext = aborted ? IDLE : ACK;
        ackNext   = ~aborted;
      end
      STAT: begin
        dataoNext = statWord;
        if (isWrReg) begin
          peNext = busDATAI[BIT_PE];
          pfNext = pfReg & busDATAI[BIT_PF];
          eeNext = ~busDATAI[BIT_EE];
        end
        stateNext = ACK;
        ackNext   = 1'b1;
      end
      ACK: begin
        stateNext = HOLD;
      end
      HOLD: begin
        // wait for the requester to release so one request gets one ack
        if (!busREQI) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // state and registered outputs, advancing only on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      ackReg   <= 1'b0;
      wrReg    <= 1'b0;
      doeReg   <= 1'b0;
      cntReg   <= 3'd0;
      dataoReg <= 36'd0;
      addrReg  <= 23'd0;
      wdataReg <= 36'd0;
      peReg    <= 1'b0;
      eeReg    <= 1'b1;
      pfReg    <= 1'b1;
      isWrReg  <= 1'b0;
      abortReg <= 1'b0;
    end else if (clken) begin
      stateReg <= stateNext;
      ackReg   <= ackNext;
      wrReg    <= wrNext;
      doeReg   <= doeNext;
      cntReg   <= cntNext;
      dataoReg <= dataoNext;
      addrReg  <= addrNext;
      wdataReg <= wdataNext;
      peReg    <= peNext;
      eeReg    <= eeNext;
      pfReg    <= pfNext;
      isWrReg  <= isWrNext;
      abortReg <= abortNext;
    end
  end

  assign busACKO    = ackReg;
  assign busDATAO   = dataoReg;
  assign ssramCLK   = clk;
  assign ssramADDR  = addrReg;
  assign ssramDATAO = wdataReg;
  assign ssramDOE   = doeReg;
  assign ssramWR    = wrReg;
  assign ssramADV   = 1'b0;

endmodule

// File: tb/tb_ks10_mem_ctrl.sv
// tb_ks10_mem_ctrl: three controllers (SSRAM latency 1, 2, 3) share one bus
// driver; each has its own SSRAM model, expected-response queue and monitor.
module tb_ks10_mem_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b1;
  logic        busReq = 1'b0;
  logic [35:0] busAddr = '0;
  logic [35:0] busData = '0;

  logic        ackW  [NI];
  logic [35:0] dataW [NI];
  logic [22:0] saddr [NI];
  logic [35:0] sdo   [NI];
  logic [35:0] sdi   [NI];
  logic        sdoe  [NI];
  logic        swr   [NI];
  logic        sadv  [NI];
  logic        sclk  [NI];

  int enCyc = 0;
  bit clkenRand = 1'b0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [35:0] data;
    bit          chkData;
    int          cyc;
  } exp_t;

  exp_t expQ [NI][$];
  int   ackCnt [NI];
  int   lastAck [NI];

  // reference model: memory contents and status bits
  logic [35:0] refMem [int];
  int          wrList [$];
  bit          mPe = 1'b0;
  bit          mEe = 1'b1;
  bit          mPf = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) if (clken) enCyc <= enCyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [35:0] mem  [0:32767];
    logic [35:0] pipe [0:3];

    ks10_mem_ctrl #(.MEM_AWIDTH(15), .SSRAM_LAT(gi + 1)) dut (
      .clk        (clk),
      .rst        (rst),
      .clken      (clken),
      .busREQI    (busReq),
      .busACKO    (ackW[gi]),
      .busADDRI   (busAddr),
      .busDATAI   (busData),
      .busDATAO   (dataW[gi]),
      .ssramCLK   (sclk[gi]),
      .ssramADDR  (saddr[gi]),
      .ssramDATAO (sdo[gi]),
      .ssramDATAI (sdi[gi]),
      .ssramDOE   (sdoe[gi]),
      .ssramWR    (swr[gi]),
      .ssramADV   (sadv[gi])
    );

    // pipelined SSRAM: free-running on clk, read data LAT clocks after the address
    always @(posedge clk) begin
      if (swr[gi]) mem[saddr[gi][14:0]] <= sdo[gi];
      pipe[0] <= mem[saddr[gi][14:0]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign sdi[gi] = pipe[gi];
  end

  task automatic check(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, required %s", name, got, want);
    end
  endtask

  function automatic logic [35:0] mkAddr(input bit rd, input bit wr, input bit io, input logic [19:0] a);
    logic [35:0] w;
    w = '0;
    w[32] = rd;
    w[30] = wr;
    w[25] = io;
    w[19:0] = a;
    return w;
  endfunction

  function automatic logic [35:0] statWord();
    return (36'(mPe) << 32) | (36'(mEe) << 31) | (36'(mPf) << 23);
  endfunction

  function automatic logic [35:0] refRead(input int a);
    return refMem.exists(a) ? refMem[a] : 36'd0;
  endfunction

  task automatic waitEn(input int n);
    int target;
    int g;
    target = enCyc + n;
    g = 0;
    while (enCyc < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  // monitor: pops the expected response whenever a controller acknowledges
  initial begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      lastAck[i] = -1;
      ackCnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NI; i++) begin
          if (ackW[i] === 1'b1 && enCyc != lastAck[i]) begin
            lastAck[i] = enCyc;
            ackCnt[i]++;
            if (expQ[i].size() == 0) begin
              check(1'b0, $sformatf("unexpectedAck lat%0d", i + 1),
                    $sformatf("ack at cycle %0d", enCyc), "no ack");
            end else begin
              e = expQ[i].pop_front();
              check(enCyc == e.cyc, $sformatf("ackCycle lat%0d", i + 1),
                    $sformatf("%0d", enCyc), $sformatf("%0d", e.cyc));
              if (e.chkData)
                check(dataW[i] === e.data, $sformatf("readData lat%0d", i + 1),
                      $sformatf("%o", dataW[i]), $sformatf("%o", e.data));
            end
          end
        end
      end
    end
  end

  // clock enable: held high, or random 1/0 when clkenRand is set
  initial begin
    forever begin
      @(negedge clk);
      clken = clkenRand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // kind: 0 memory read, 1 memory write, 2 status read, 3 status write
  task automatic doReq(input int kind, input int a, input logic [35:0] d,
                       input int holdExtra, input bit abortIt);
    exp_t e;
    int   n;
    int   g;
    int   base [NI];
    bit   isWr;
    bit   isMem;
    bit   done;
    isWr  = (kind == 1) || (kind == 3);
    isMem = (kind < 2);
    busAddr = mkAddr(isWr ? 1'($urandom_range(0, 1)) : 1'b1, isWr, !isMem,
                     isMem ? 20'(a) : 20'o100000);
    busData = d;
    busReq  = 1'b1;
    n = enCyc + 1;
    for (int i = 0; i < NI; i++) begin
      base[i] = ackCnt[i];
      if (!abortIt) begin
        e.cyc     = n + 1 + ((kind == 0) ? (i + 1) : 0);
        e.chkData = (kind == 0) || (kind == 2);
        e.data    = (kind == 0) ? refRead(a) : statWord();
        expQ[i].push_back(e);
      end
    end
    if (kind == 1) begin
      refMem[a] = d;
      wrList.push_back(a);
    end else if (kind == 3) begin
      mPe = d[32];
      mPf = mPf & d[23];
      mEe = ~d[0];
    end
    g = 0;
    while (enCyc < n && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (isMem) begin
      for (int i = 0; i < NI; i++)
        check(swr[i] === isWr && sdoe[i] === isWr && saddr[i] === 23'(a) &&
              (!isWr || sdo[i] === d),
              $sformatf("ssramCycle lat%0d", i + 1),
              $sformatf("wr=%b doe=%b addr=%o dout=%o", swr[i], sdoe[i], saddr[i], sdo[i]),
              $sformatf("wr=%b doe=%b addr=%o dout=%o", isWr, isWr, 23'(a), isWr ? d : sdo[i]));
    end
    if (abortIt) begin
      busReq = 1'b0;
      waitEn(8);
      for (int i = 0; i < NI; i++)
        check(ackCnt[i] == base[i], $sformatf("abortNoAck lat%0d", i + 1),
              $sformatf("%0d acks", ackCnt[i] - base[i]), "0 acks");
    end else begin
      g = 0;
      done = 1'b0;
      while (!done && g < 300) begin
        @(negedge clk);
        g++;
        done = 1'b1;
        for (int i = 0; i < NI; i++) if (ackCnt[i] == base[i]) done = 1'b0;
      end
      if (!done) begin
        check(1'b0, "ackTimeout", "no ack within 300 clocks", "ack");
        for (int i = 0; i < NI; i++) expQ[i].delete();
      end
      repeat (holdExtra) @(negedge clk);
      if (holdExtra > 0)
        for (int i = 0; i < NI; i++)
          check(ackCnt[i] == base[i] + 1, $sformatf("heldReqOneAck lat%0d", i + 1),
                $sformatf("%0d acks", ackCnt[i] - base[i]), "1 ack");
      busReq = 1'b0;
      waitEn(2 + int'($urandom_range(0, 2)));
    end
    $display("txn kind=%0d addr=%o data=%o abort=%0d cycle=%0d", kind, a, d, abortIt, n);
  endtask

  // request that must be ignored: no ack and no SSRAM write for 20 cycles
  task automatic noAck(input logic [35:0] w, input string name);
    int  base [NI];
    bit  sawWr;
    int  target;
    int  g;
    busAddr = w;
    busData = '1;
    busReq  = 1'b1;
    for (int i = 0; i < NI; i++) base[i] = ackCnt[i];
    sawWr = 1'b0;
    target = enCyc + 20;
    g = 0;
    while (enCyc < target && g < 1000) begin
      @(negedge clk);
      g++;
      for (int i = 0; i < NI; i++) if (swr[i] !== 1'b0) sawWr = 1'b1;
    end
    for (int i = 0; i < NI; i++)
      check(ackCnt[i] == base[i] && !sawWr, $sformatf("%s lat%0d", name, i + 1),
            $sformatf("acks=%0d wr=%b", ackCnt[i] - base[i], sawWr), "acks=0 wr=0");
    busReq = 1'b0;
    waitEn(2);
    $display("txn ignored addr=%o", w);
  endtask

  // reset asserted while every controller is in RD
  task automatic resetInRead(input int a);
    int n;
    int g;
    busAddr = mkAddr(1'b1, 1'b0, 1'b0, 20'(a));
    busReq  = 1'b1;
    n = enCyc + 1;
    g = 0;
    while (enCyc < n + 1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      check(ackW[i] === 1'b0 && swr[i] === 1'b0 && dataW[i] === 36'd0 && saddr[i] === 23'd0,
            $sformatf("resetInRd lat%0d", i + 1),
            $sformatf("ack=%b wr=%b data=%o addr=%o", ackW[i], swr[i], dataW[i], saddr[i]),
            "ack=0 wr=0 data=0 addr=0");
    @(negedge clk);
    busReq = 1'b0;
    rst = 1'b0;
    mPe = 1'b0;
    mEe = 1'b1;
    mPf = 1'b1;
    waitEn(2);
    $display("txn reset during read addr=%o", a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int a;
    logic [35:0] d;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check(ackW[i] === 1'b0 && dataW[i] === 36'd0 && saddr[i] === 23'd0 && sdo[i] === 36'd0 &&
            swr[i] === 1'b0 && sdoe[i] === 1'b0 && sadv[i] === 1'b0,
            $sformatf("resetValues lat%0d", i + 1),
            $sformatf("ack=%b data=%o addr=%o dout=%o wr=%b doe=%b adv=%b",
                      ackW[i], dataW[i], saddr[i], sdo[i], swr[i], sdoe[i], sadv[i]),
            "all zero");
    rst = 1'b0;
    @(negedge clk);

    // status after reset, then write/read the example word
    doReq(2, 0, '0, 0, 1'b0);
    doReq(1, 'o1000, 36'o123456701234, 0, 1'b0);
    doReq(0, 'o1000, '0, 0, 1'b0);

    // status write: PE=1, PF cleared, EE cleared; second write cannot set PF
    d = '0;
    d[32] = 1'b1;
    d[0]  = 1'b1;
    doReq(3, 0, d, 0, 1'b0);
    doReq(2, 0, '0, 0, 1'b0);
    d[23] = 1'b1;
    doReq(3, 0, d, 0, 1'b0);
    doReq(2, 0, '0, 0, 1'b0);

    // ignored requests: out of range memory and wrong status device
    noAck(mkAddr(1'b1, 1'b0, 1'b0, 20'o100000), "nxmNoAck");
    noAck(mkAddr(1'b1, 1'b0, 1'b1, 20'o100000) | (36'd1 << 20), "badDevNoAck");

    // top of memory, held request, and a read with clock enable toggling
    doReq(1, 32767, 36'o777777777777, 0, 1'b0);
    doReq(0, 32767, '0, 10, 1'b0);
    clkenRand = 1'b1;
    doReq(0, 'o1000, '0, 0, 1'b0);
    clkenRand = 1'b0;

    // aborted read, aborted write still writes, then read it back
    doReq(0, 'o1000, '0, 0, 1'b1);
    doReq(1, 'o2000, 36'o555555000111, 0, 1'b1);
    doReq(0, 'o2000, '0, 0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      clkenRand = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      d = {4'($urandom), 32'($urandom)};
      case ($urandom_range(0, 7))
        0: a = 0;
        1: a = 32767;
        default: a = int'($urandom_range(0, 32767));
      endcase
      if (kind == 0) a = wrList[$urandom_range(0, wrList.size() - 1)];
      doReq(kind, a, d, 0, 1'b0);
    end
    clkenRand = 1'b0;
    waitEn(2);

    // reset during a read, then a normal read and status read
    resetInRead('o1000);
    doReq(0, 'o1000, '0, 0, 1'b0);
    doReq(2, 0, '0, 0, 1'b0);

    for (int i = 0; i < NI; i++)
      check(expQ[i].size() == 0, $sformatf("pendingAcks lat%0d", i + 1),
            $sformatf("%0d", expQ[i].size()), "0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
